// File: rtl/ex_muldiv_sequencer.sv
// RV32M multiply/divide sequencer: iterative shift-add multiply and restoring divide beside the EX ALU.
// Optional MULDIV_EARLY_OUT_EN: multiply leaves CALC once the remaining multiplier bits are all zero.
module ex_muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      result_rd
);

  // state | meaning
  // IDLE  | waiting for start; operands latched on accept
  // PREP  | magnitudes, result signs, special-case detect
  // CALC  | one multiplier/quotient bit per cycle
  // FIN   | result registered, done high
  typedef enum logic [1:0] {IDLE, PREP, CALC, FIN} state_t;

  localparam int CW = $clog2(XLEN);

  state_t              state;
  logic [2:0]          op_q;
  logic [4:0]          rd_q;
  logic [XLEN-1:0]     a_q, b_q;
  logic                sign_q, sign_r;
  logic [2*XLEN-1:0]   prod, mcand;
  logic [XLEN-1:0]     mplier;
  logic [XLEN:0]       rem;
  logic [CW-1:0]       cnt;

  logic                a_sgn, b_sgn, sa, sb, is_div, div_zero, div_ovf;
  logic [XLEN-1:0]     a_mag, b_mag, spec_val;
  logic [2*XLEN-1:0]   prod_nxt, prod_fix;
  logic [XLEN+1:0]     rem_sh, rem_diff;
  logic                q_bit;
  logic [XLEN:0]       rem_nxt;
  logic [XLEN-1:0]     quo_nxt, quo_fix, rem_fix, calc_val;
  logic                calc_last;

  always_comb begin
    a_sgn    = (op_q == 3'b001) || (op_q == 3'b010) || (op_q == 3'b100) || (op_q == 3'b110);
    b_sgn    = (op_q == 3'b001) || (op_q == 3'b100) || (op_q == 3'b110);
    sa       = a_sgn & a_q[XLEN-1];
    sb       = b_sgn & b_q[XLEN-1];
    a_mag    = sa ? -a_q : a_q;
    b_mag    = sb ? -b_q : b_q;
    is_div   = op_q[2];
    div_zero = is_div && (b_q == '0);
    div_ovf  = is_div && !op_q[0] && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
    if (div_zero) spec_val = op_q[1] ? a_q : '1;
    else          spec_val = op_q[1] ? '0 : a_q;

    prod_nxt = prod + (mplier[0] ? mcand : '0);

    // the extra top bit of the widened partial remainder carries the borrow
    rem_sh   = {rem, mplier[XLEN-1]};
    rem_diff = rem_sh - {2'b00, mcand[XLEN-1:0]};
    q_bit    = ~rem_diff[XLEN+1];
    rem_nxt  = q_bit ? rem_diff[XLEN:0] : rem_sh[XLEN:0];
    quo_nxt  = {mplier[XLEN-2:0], q_bit};

    prod_fix = sign_q ? -prod_nxt : prod_nxt;
    quo_fix  = sign_q ? -quo_nxt : quo_nxt;
    rem_fix  = sign_r ? -rem_nxt[XLEN-1:0] : rem_nxt[XLEN-1:0];
    if (is_div)               calc_val = op_q[1] ? rem_fix : quo_fix;
    else if (op_q[1:0] == '0) calc_val = prod_fix[XLEN-1:0];
    else                      calc_val = prod_fix[2*XLEN-1:XLEN];

`ifdef MULDIV_EARLY_OUT_EN
    calc_last = (cnt == CW'(XLEN-1)) || (!is_div && ((mplier >> 1) == '0));
`else
    calc_last = (cnt == CW'(XLEN-1));
`endif
  end

  assign busy      = (state != IDLE);
  assign stall_req = (start && state == IDLE) || state == PREP || state == CALC;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      prod      <= '0;
      mcand     <= '0;
      mplier    <= '0;
      rem       <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      result    <= '0;
      result_rd <= '0;
    end else if (flush && state != IDLE) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !flush) begin
            op_q  <= op;
            rd_q  <= rd_in;
            a_q   <= a;
            b_q   <= b;
            state <= PREP;
          end
        end
        PREP: begin
          cnt    <= '0;
          prod   <= '0;
          rem    <= '0;
          sign_q <= sa ^ sb;
          sign_r <= sa;
          if (is_div) begin
            mplier <= a_mag;
            mcand  <= {{XLEN{1'b0}}, b_mag};
          end else begin
            mplier <= b_mag;
            mcand  <= {{XLEN{1'b0}}, a_mag};
          end
          if (div_zero || div_ovf) begin
            result    <= spec_val;
            result_rd <= rd_q;
            done      <= 1'b1;
            state     <= FIN;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          if (is_div) begin
            rem    <= rem_nxt;
            mplier <= quo_nxt;
          end else begin
            prod   <= prod_nxt;
            mplier <= mplier >> 1;
            mcand  <= mcand << 1;
          end
          // result is registered on the way into FIN so it is valid alongside done
          if (calc_last) begin
            result    <= calc_val;
            result_rd <= rd_q;
            done      <= 1'b1;
            state     <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Scoreboard bench for ex_muldiv_sequencer: directed RV32M vectors, flush and reset-abort cases.
module tb_ex_muldiv_sequencer;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b, result;
  logic [4:0]  rd_in, result_rd;
  logic        busy, stall_req, done;

  ex_muldiv_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .rd_in(rd_in),
    .flush(flush), .busy(busy), .stall_req(stall_req), .done(done),
    .result(result), .result_rd(result_rd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          t;
  } exp_t;
  exp_t sb[$];

  int nvec = 0;
  int nerr = 0;
  logic [31:0] last_exp = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    nvec++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // expected start-to-done latency of a non-special multiply
  function automatic int mul_lat(input logic [2:0] f, input logic [31:0] y);
    logic [31:0] m;
    int h;
    m = (f == 3'b001 && y[31]) ? -y : y;
    h = 0;
    for (int i = 0; i < 32; i++) if (m[i]) h = i;
    return EARLY ? 3 + h : 34;
  endfunction

  // monitor: every done pops one expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_done: result %h rd %0d, expected no done (cycle %0d)", result, result_rd, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("result_rd", 32'(result_rd), 32'(e.rd));
        chk("done_cycle", 32'(cyc), 32'(e.t));
      end
    end
  end

  // call just after a negedge; returns at the following negedge
  task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] r, input logic [31:0] e, input int lat, input bit expect_done);
    op = f; a = x; b = y; rd_in = r; start = 1'b1;
    if (expect_done) begin
      sb.push_back('{e, r, cyc + lat});
      last_exp = e;
    end
    #1;
    chk("stall_on_accept", 32'(stall_req), 32'd1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 80; i++) begin
      if (!busy) return;
      @(negedge clk);
    end
    nvec++;
    nerr++;
    $display("FAIL idle_timeout: busy %b, expected 0 within 80 cycles", busy);
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] x, y, e;
    bit          sp;
  } vec_t;

  vec_t tbl [16] = '{
    '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0},
    '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0},
    '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0},
    '{3'b000, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD, 1'b0},
    '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0},
    '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0},
    '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0},
    '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0},
    '{3'b101, 32'd100,       32'd7,         32'd14,        1'b0},
    '{3'b111, 32'd100,       32'd7,         32'd2,         1'b0},
    '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1},
    '{3'b110, 32'd5,         32'd0,         32'd5,         1'b1},
    '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1},
    '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1},
    '{3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0},
    '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0}
  };

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, bad;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0; rd_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_result_rd", 32'(result_rd), 32'd0);
    @(negedge clk);

    // MUL 7*6 with stall window check
    lat = mul_lat(3'b000, 32'd6);
    issue(3'b000, 32'd7, 32'd6, 5'd3, 32'd42, lat, 1'b1);
    bad = 0;
    for (int k = 1; k <= lat; k++) begin
      if (stall_req !== (k < lat)) bad++;
      if (k < lat) @(negedge clk);
    end
    chk("stall_window_bad_cycles", 32'(bad), 32'd0);
    wait_idle();

    foreach (tbl[i]) begin
      lat = tbl[i].sp ? 2 : (tbl[i].f[2] ? 34 : mul_lat(tbl[i].f, tbl[i].y));
      issue(tbl[i].f, tbl[i].x, tbl[i].y, 5'(i + 4), tbl[i].e, lat, 1'b1);
      wait_idle();
    end

    // flush a DIV at cycle 10, then MUL 3*4 starting at cycle 11
    issue(3'b100, 32'd1000, 32'd3, 5'd30, 32'd0, 0, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_result_held", result, last_exp);
    issue(3'b000, 32'd3, 32'd4, 5'd31, 32'd12, mul_lat(3'b000, 32'd4), 1'b1);
    wait_idle();

    // reset pulse at cycle 20 of a MUL
    issue(3'b000, 32'd9, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFF7, mul_lat(3'b000, 32'hFFFF_FFFF), 1'b1);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_stall", 32'(stall_req), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", result, 32'd0);
    sb.delete();
    last_exp = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(3'b011, 32'h0001_0000, 32'h0001_0000, 5'd17, 32'h0000_0001, mul_lat(3'b011, 32'h0001_0000), 1'b1);
    wait_idle();

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
